// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage bus bundle
// Purpose: groups the MEM-stage capture inputs, data-memory load return and
//          register-file write port of mem_wb_stage.
// Ports (slave = stage view):
//   in : mem_valid, mem_flush, mem_reg_write, mem_dst_reg[3:0], mem_wb_sel[1:0],
//        mem_alu_result[15:0], mem_pc_plus2[15:0], dmem_rvalid, dmem_rdata[15:0]
//   out: DstReg[3:0], DstData[15:0], WriteReg, wb_stall, halt, load_err,
//        retired_count[CNT_W-1:0]
interface mem_wb_stage_if #(
   parameter int CNT_W = 16
);
   logic             mem_valid;
   logic             mem_flush;
   logic             mem_reg_write;
   logic [3:0]       mem_dst_reg;
   logic [1:0]       mem_wb_sel;
   logic [15:0]      mem_alu_result;
   logic [15:0]      mem_pc_plus2;
   logic             dmem_rvalid;
   logic [15:0]      dmem_rdata;
   logic [3:0]       DstReg;
   logic [15:0]      DstData;
   logic             WriteReg;
   logic             wb_stall;
   logic             halt;
   logic             load_err;
   logic [CNT_W-1:0] retired_count;

   modport slave (
      input  mem_valid, mem_flush, mem_reg_write, mem_dst_reg, mem_wb_sel,
             mem_alu_result, mem_pc_plus2, dmem_rvalid, dmem_rdata,
      output DstReg, DstData, WriteReg, wb_stall, halt, load_err, retired_count
   );

   modport master (
      output mem_valid, mem_flush, mem_reg_write, mem_dst_reg, mem_wb_sel,
             mem_alu_result, mem_pc_plus2, dmem_rvalid, dmem_rdata,
      input  DstReg, DstData, WriteReg, wb_stall, halt, load_err, retired_count
   );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and writeback controller
// Purpose: captures retiring instructions, selects ALU / load / PC+2 writeback
//          data, stalls while a load is outstanding (with timeout) and latches halt.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_wb_stage_if.slave (capture inputs, load return, regfile write port,
//          stall / halt / load_err / retired_count status)
module mem_wb_stage #(
   parameter int LOAD_TIMEOUT = 16,
   parameter int CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst,
   mem_wb_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      S_RUN,
      S_WAIT_LOAD,
      S_LOAD_WB,
      S_HALTED
   } state_t;

   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC   = 2'b10;
   localparam logic [1:0] SEL_HALT = 2'b11;
   localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

   state_t           state;
   logic             wb_valid;
   logic             wb_reg_write;
   logic [3:0]       wb_dst;
   logic [1:0]       wb_sel;
   logic [15:0]      wb_data;
   logic [15:0]      load_data;
   logic [7:0]       tmo_cnt;
   logic             load_err_q;
   logic [CNT_W-1:0] retired_q;

   logic             capture;
   logic             cap_valid;
   logic             retire_run;
   logic             retire_lwb;
   logic             retire_halt;
   logic [CNT_W-1:0] retire_inc;

   // The stage captures on every edge where it is not stalling.
   assign capture   = (state == S_RUN) || (state == S_LOAD_WB);
   assign cap_valid = bus.mem_valid & ~bus.mem_flush;

   // A RUN-state ALU/PC+2 op retires as it is replaced; a halt counts as it is
   // captured, so an ALU op followed by halt bumps the count by two at one edge.
   assign retire_run  = (state == S_RUN) && wb_valid && (wb_sel != SEL_LOAD);
   assign retire_lwb  = (state == S_LOAD_WB);
   assign retire_halt = capture && cap_valid && (bus.mem_wb_sel == SEL_HALT);
   assign retire_inc  = CNT_W'(retire_run | retire_lwb) + CNT_W'(retire_halt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_RUN;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_dst       <= 4'd0;
         wb_sel       <= 2'b00;
         wb_data      <= 16'd0;
         load_data    <= 16'd0;
         tmo_cnt      <= 8'd0;
         load_err_q   <= 1'b0;
         retired_q    <= '0;
      end else begin
         retired_q <= retired_q + retire_inc;
         case (state)
            S_RUN, S_LOAD_WB: begin
               wb_valid     <= cap_valid;
               wb_reg_write <= bus.mem_reg_write;
               wb_dst       <= bus.mem_dst_reg;
               wb_sel       <= bus.mem_wb_sel;
               wb_data      <= (bus.mem_wb_sel == SEL_PC) ? bus.mem_pc_plus2
                                                          : bus.mem_alu_result;
               tmo_cnt      <= 8'd0;
               if (cap_valid && bus.mem_wb_sel == SEL_HALT)
                  state <= S_HALTED;
               else if (cap_valid && bus.mem_wb_sel == SEL_LOAD)
                  state <= S_WAIT_LOAD;
               else
                  state <= S_RUN;
            end
            S_WAIT_LOAD: begin
               if (bus.dmem_rvalid) begin
                  load_data <= bus.dmem_rdata;
                  state     <= S_LOAD_WB;
               end else if (tmo_cnt == TMO_LAST) begin
                  // Abandon the load: it is neither written nor counted.
                  load_err_q <= 1'b1;
                  wb_valid   <= 1'b0;
                  state      <= S_RUN;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= S_HALTED;
         endcase
      end
   end

   always_comb begin
      bus.WriteReg = 1'b0;
      bus.DstData  = wb_data;
      case (state)
         S_RUN:     bus.WriteReg = wb_valid & wb_reg_write & (wb_sel != SEL_LOAD) &
                                   (wb_dst != 4'd0);
         S_LOAD_WB: begin
            bus.WriteReg = wb_reg_write & (wb_dst != 4'd0);
            bus.DstData  = load_data;
         end
         default:   bus.WriteReg = 1'b0;
      endcase
   end

   assign bus.DstReg        = wb_dst;
   assign bus.wb_stall      = (state == S_WAIT_LOAD) || (state == S_HALTED);
   assign bus.halt          = (state == S_HALTED);
   assign bus.load_err      = load_err_q;
   assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_wb_stage_if #(.CNT_W(16)) bus ();

   mem_wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic fl, input logic rw, input logic [3:0] dst,
                        input logic [1:0] sel, input logic [15:0] alu, input logic [15:0] pc);
      bus.mem_valid      = v;
      bus.mem_flush      = fl;
      bus.mem_reg_write  = rw;
      bus.mem_dst_reg    = dst;
      bus.mem_wb_sel     = sel;
      bus.mem_alu_result = alu;
      bus.mem_pc_plus2   = pc;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 16'd0, 16'd0);
   endtask

   // Advance one clock; inputs change and outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_we"},    32'(bus.WriteReg), 32'd0);
      check_eq({tag, "_dst"},   32'(bus.DstReg), 32'd0);
      check_eq({tag, "_data"},  32'(bus.DstData), 32'd0);
      check_eq({tag, "_stall"}, 32'(bus.wb_stall), 32'd0);
      check_eq({tag, "_halt"},  32'(bus.halt), 32'd0);
      check_eq({tag, "_lerr"},  32'(bus.load_err), 32'd0);
      check_eq({tag, "_cnt"},   32'(bus.retired_count), 32'd0);
   endtask

   task automatic check_wr(input string tag, input logic we, input logic [3:0] dst,
                           input logic [15:0] data);
      check_eq({tag, "_we"}, 32'(bus.WriteReg), 32'(we));
      check_eq({tag, "_dst"}, 32'(bus.DstReg), 32'(dst));
      check_eq({tag, "_data"}, 32'(bus.DstData), 32'(data));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 16'd0;
      idle();
      @(negedge clk);
      step();
      check_all_zero("reset");
      rst = 1'b1;

      // ALU write to r5
      drive(1'b1, 1'b0, 1'b1, 4'd5, 2'b00, 16'h1234, 16'h0);
      step();
      check_wr("alu", 1'b1, 4'd5, 16'h1234);
      check_eq("alu_stall", 32'(bus.wb_stall), 32'd0);
      idle();
      step();
      check_eq("alu_cnt", 32'(bus.retired_count), 32'd1);
      check_eq("alu_we_off", 32'(bus.WriteReg), 32'd0);

      // Load to r3, data returns on the third stall cycle; ALU r7 waits upstream
      drive(1'b1, 1'b0, 1'b1, 4'd3, 2'b01, 16'hDEAD, 16'h0);
      step();
      check_eq("ld_stall1", 32'(bus.wb_stall), 32'd1);
      check_eq("ld_we1", 32'(bus.WriteReg), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 4'd7, 2'b00, 16'h0777, 16'h0);
      step();
      check_eq("ld_stall2", 32'(bus.wb_stall), 32'd1);
      step();
      check_eq("ld_stall3", 32'(bus.wb_stall), 32'd1);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 16'hBEEF;
      step();
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 16'h0;
      check_eq("ld_wb_stall", 32'(bus.wb_stall), 32'd0);
      check_wr("ld_wb", 1'b1, 4'd3, 16'hBEEF);
      check_eq("ld_wb_cnt", 32'(bus.retired_count), 32'd1);
      step();
      check_wr("after_ld", 1'b1, 4'd7, 16'h0777);
      check_eq("after_ld_cnt", 32'(bus.retired_count), 32'd2);
      idle();
      step();
      check_eq("after_ld_cnt2", 32'(bus.retired_count), 32'd3);

      // R0 never written, flush drops, PC+2 link to r15
      drive(1'b1, 1'b0, 1'b1, 4'd0, 2'b00, 16'h5555, 16'h0);
      step();
      check_eq("r0_we", 32'(bus.WriteReg), 32'd0);
      drive(1'b1, 1'b1, 1'b1, 4'd9, 2'b00, 16'h9999, 16'h0);
      step();
      check_eq("r0_cnt", 32'(bus.retired_count), 32'd4);
      check_eq("flush_we", 32'(bus.WriteReg), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 4'd15, 2'b10, 16'h1111, 16'h0042);
      step();
      check_eq("flush_cnt", 32'(bus.retired_count), 32'd4);
      check_wr("pc2", 1'b1, 4'd15, 16'h0042);
      idle();
      step();
      check_eq("pc2_cnt", 32'(bus.retired_count), 32'd5);

      // Load timeout after 4 stall cycles; ALU r6 waits upstream
      drive(1'b1, 1'b0, 1'b1, 4'd4, 2'b01, 16'h0, 16'h0);
      step();
      drive(1'b1, 1'b0, 1'b1, 4'd6, 2'b00, 16'h0666, 16'h0);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("tmo_stall%0d", i), 32'(bus.wb_stall), 32'd1);
         check_eq($sformatf("tmo_we%0d", i), 32'(bus.WriteReg), 32'd0);
         check_eq($sformatf("tmo_err%0d", i), 32'(bus.load_err), 32'd0);
         step();
      end
      check_eq("tmo_resume", 32'(bus.wb_stall), 32'd0);
      check_eq("tmo_err", 32'(bus.load_err), 32'd1);
      check_eq("tmo_we", 32'(bus.WriteReg), 32'd0);
      check_eq("tmo_cnt", 32'(bus.retired_count), 32'd5);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 16'hAAAA;
      step();
      bus.dmem_rvalid = 1'b0;
      check_wr("tmo_next", 1'b1, 4'd6, 16'h0666);
      check_eq("tmo_next_cnt", 32'(bus.retired_count), 32'd5);
      idle();
      step();
      check_eq("late_rv_stall", 32'(bus.wb_stall), 32'd0);
      check_eq("tmo_err_sticky", 32'(bus.load_err), 32'd1);
      check_eq("tmo_next_cnt2", 32'(bus.retired_count), 32'd6);

      // ALU, halt, ALU: only the first is written; halt counts
      drive(1'b1, 1'b0, 1'b1, 4'd2, 2'b00, 16'h2222, 16'h0);
      step();
      check_wr("pre_halt", 1'b1, 4'd2, 16'h2222);
      drive(1'b1, 1'b0, 1'b1, 4'd1, 2'b11, 16'h1, 16'h0);
      step();
      drive(1'b1, 1'b0, 1'b1, 4'd8, 2'b00, 16'h8888, 16'h0);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("halt%0d", i), 32'(bus.halt), 32'd1);
         check_eq($sformatf("halt_stall%0d", i), 32'(bus.wb_stall), 32'd1);
         check_eq($sformatf("halt_we%0d", i), 32'(bus.WriteReg), 32'd0);
         check_eq($sformatf("halt_cnt%0d", i), 32'(bus.retired_count), 32'd8);
         step();
      end

      // Reset out of HALTED, then async reset while a load is outstanding
      rst = 1'b0;
      idle();
      step();
      check_all_zero("rst_halt");
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 4'd3, 2'b01, 16'h0, 16'h0);
      step();
      check_eq("rst_ld_stall", 32'(bus.wb_stall), 32'd1);
      check_eq("rst_ld_dst", 32'(bus.DstReg), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 4'd10, 2'b00, 16'hA0A0, 16'h0);
      step();
      check_wr("post_rst", 1'b1, 4'd10, 16'hA0A0);
      idle();
      step();
      check_eq("post_rst_cnt", 32'(bus.retired_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback controller for the 16-bit, 16-entry-register CPU. It captures retiring instructions from the MEM stage and selects the writeback value: ALU result, load data or PC+2. It drives the register file write port (DstReg, DstData, WriteReg). It stalls upstream while a load waits for data, and it latches halt.

Parameters:
LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before the load is abandoned (range 2..255)
CNT_W, 16, width of retired_count

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
mem_valid  in  1  MEM stage presents an instruction
mem_flush  in  1  kill the instruction being captured this edge
mem_reg_write  in  1  instruction writes a register
mem_dst_reg  in  4  destination register id
mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+2, 11 halt
mem_alu_result  in  16  ALU result
mem_pc_plus2  in  16  link value
dmem_rvalid  in  1  load data valid (one-cycle pulse)
dmem_rdata  in  16  load data
DstReg  out  4  register file write id
DstData  out  16  register file write data
WriteReg  out  1  register file write enable
wb_stall  out  1  hold MEM stage; upstream must keep mem_* stable
halt  out  1  processor halted
load_err  out  1  sticky: a load timed out
retired_count  out  CNT_W  instructions retired, wraps

Behaviour:
- Stage registers: wb_valid, wb_reg_write, wb_dst, wb_sel, wb_data (16), load_data (16); FSM state; timeout counter (8 b).
- Capture: at a clock edge with wb_stall=0, load all stage registers from mem_*.
  - wb_valid <= mem_valid & ~mem_flush.
  - wb_data <= mem_pc_plus2 if mem_wb_sel=10, else mem_alu_result.
- Next state after a capture, taken from the captured instruction:
  - valid and sel=11 -> HALTED
  - valid and sel=01 -> WAIT_LOAD
  - otherwise -> RUN
- States:
  - RUN: wb_stall=0. WriteReg = wb_valid & wb_reg_write & (wb_sel != 01) & (wb_dst != 0). DstData = wb_data. Capture every edge.
  - WAIT_LOAD: wb_stall=1, WriteReg=0.
    - On dmem_rvalid: load_data <= dmem_rdata, go to LOAD_WB.
    - Otherwise the counter increments. If the counter equals LOAD_TIMEOUT-1 with no rvalid: set load_err, clear wb_valid, go to RUN. That load is neither written nor counted.
    - dmem_rvalid in any other state is ignored.
  - LOAD_WB: wb_stall=0. WriteReg = wb_reg_write & (wb_dst != 0). DstData = load_data. The next capture occurs at the end of this cycle.
  - HALTED: halt=1, wb_stall=1, WriteReg=0. Exit only by reset. The halt instruction writes nothing.
- Outputs are combinational from state and stage registers, with no internal bypass.
  - The register file performs the same-cycle read/write bypass on DstReg/DstData.
  - DstReg = wb_dst in every state.
- R0 is never written: WriteReg is forced to 0 when wb_dst=0.
- retired_count increments by 1 when a valid instruction completes:
  - on leaving RUN with wb_valid=1 and the instruction not a load;
  - in LOAD_WB;
  - on entering HALTED (the halt counts).
  - It wraps at 2^CNT_W.
- The timeout counter is cleared on entry to WAIT_LOAD.
- Flush never affects an instruction already captured, including one in WAIT_LOAD.
- Reset (async, rst=0), including mid-WAIT_LOAD: state=RUN, wb_valid=0, all stage registers 0, counters 0, load_err=0.
  - Outputs during reset: WriteReg=0, DstReg=0, DstData=0, wb_stall=0, halt=0, retired_count=0.

Test Plan:
- ALU writes: capture mem_valid=1, reg_write=1, dst=5, sel=00, alu=0x1234 -> next cycle WriteReg=1, DstReg=5, DstData=0x1234, retired_count=1.
- Load with latency 3: capture load dst=3, rvalid with rdata=0xBEEF three cycles later -> wb_stall=1 for 3 cycles, then one cycle WriteReg=1, DstData=0xBEEF; a following ALU op is captured at that edge and written the next cycle.
- R0, flush and PC+2:
  - dst=0 ALU op -> WriteReg stays 0, count increments.
  - mem_flush=1 with mem_valid=1 -> no write, no count.
  - sel=10, pc_plus2=0x0042, dst=15 -> DstData=0x0042.
- Timeout: load captured, no rvalid, LOAD_TIMEOUT=4 -> stall for 4 cycles, load_err=1 and sticky, no write, retired_count unchanged, pipeline resumes. A late rvalid is ignored.
- Halt: ALU op, then halt, then ALU op -> first op written, halt=1 and wb_stall=1 forever, third op never written, retired_count=2.
- Reset while in WAIT_LOAD -> all outputs 0 immediately (async). After release, a new ALU op retires normally.
